// File: rtl/ixu_pkg.sv
// ixu_pkg: shared branch-info pack sizing and index types
package ixu_pkg;
  localparam int BINFO_DEPTH = 16;
  localparam int BINFO_PTR_W = 4;
  typedef logic [BINFO_PTR_W-1:0] pack_t;
  typedef logic [BINFO_PTR_W:0] pack_ext_t;
endpackage

// File: rtl/ixu_binfo_alloc.sv
// ixu_binfo_alloc: branch-info pack allocator with commit free and mispredict rollback; IXU_BINFO_ALLOC_STATS_EN adds stall/high-watermark counters
module ixu_binfo_alloc
  import ixu_pkg::*;
#(
  parameter int DEPTH = BINFO_DEPTH,
  parameter int PTR_W = BINFO_PTR_W
) (
  input  logic             core_clock_i,
  input  logic             core_reset_n_i,
  input  logic             rn_alloc_vld_i,
  output logic             rn_alloc_rdy_o,
  output logic [PTR_W-1:0] rn_btb_pack_o,
  output logic             rn_btb_wen_o,
  input  logic             cmt_free_i,
  output logic [PTR_W-1:0] cmt_pack_o,
  input  logic             flush_i,
  input  logic             bmiss_i,
  input  logic [PTR_W-1:0] bmiss_pack_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [PTR_W:0]   count_o,
  output logic             err_o,
  output logic [31:0]      stat_stall_o,
  output logic [PTR_W:0]   stat_hwm_o
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  function automatic logic [PTR_W:0] ext_pack(input logic [PTR_W:0] h, input logic [PTR_W-1:0] p);
    return {h[PTR_W] ^ (p < h[PTR_W-1:0]), p};
  endfunction
  function automatic logic in_live(input logic [PTR_W:0] h, input logic [PTR_W:0] t, input logic [PTR_W:0] e);
    return (PTR_W+1)'(e - h) < (PTR_W+1)'(t - h);
  endfunction
  logic [PTR_W:0] head_q, tail_q, bm_ext, head_nx, tail_nx;
  logic do_free, bm_act, bm_ok, bm_err;
  assign count_o        = tail_q - head_q;
  assign empty_o        = count_o == '0;
  assign full_o         = count_o == FULL_CNT;
  assign rn_alloc_rdy_o = !full_o & !flush_i & !bmiss_i;
  assign rn_btb_wen_o   = rn_alloc_vld_i & rn_alloc_rdy_o;
  assign rn_btb_pack_o  = tail_q[PTR_W-1:0];
  assign cmt_pack_o     = head_q[PTR_W-1:0];
  assign do_free        = cmt_free_i & !empty_o;
  assign bm_act         = bmiss_i & !flush_i;
  assign bm_ext         = ext_pack(head_q, bmiss_pack_i);
  assign bm_ok          = in_live(head_q, tail_q, bm_ext);
  assign bm_err         = bm_act & !bm_ok;
  // next pointers: flush collapses tail onto the post-free head, a valid mispredict truncates after the faulting pack
  always_comb begin
    head_nx = head_q + (PTR_W+1)'(do_free);
    tail_nx = flush_i ? head_nx : (bm_act & bm_ok) ? bm_ext + 1'b1 : tail_q + (PTR_W+1)'(rn_btb_wen_o);
  end
  // pointer and sticky error state
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      err_o  <= 1'b0;
    end else begin
      head_q <= head_nx;
      tail_q <= tail_nx;
      err_o  <= err_o | (cmt_free_i & empty_o) | bm_err;
    end
  end
`ifdef IXU_BINFO_ALLOC_STATS_EN
  logic [31:0]    stall_q;
  logic [PTR_W:0] hwm_q;
  // saturating stall counter and occupancy high-watermark
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      stall_q <= '0;
      hwm_q   <= '0;
    end else begin
      if (rn_alloc_vld_i & !rn_alloc_rdy_o & ~&stall_q) stall_q <= stall_q + 32'd1;
      if (count_o > hwm_q) hwm_q <= count_o;
    end
  end
  assign stat_stall_o = stall_q;
  assign stat_hwm_o   = hwm_q;
`else
  assign stat_stall_o = '0;
  assign stat_hwm_o   = '0;
`endif
endmodule
